pwm_servo_bank: RTL and testbench

Multi-channel servo PWM generator: NCH outputs share one frame counter and one period, each with its own duty. Duty and period writes are double-buffered and take effect only at frame boundaries, so outputs never glitch. This is the next generation of the single-channel servo PWM and drives all servo outputs of the cube-rotation mechanism from one block. At 100 MHz, 100000 cycles = 1 ms and a 20 ms frame is 2000000 cycles.

---
 rtl/pwm_servo_bank.sv | 126 ++++++++++++
 tb/tb_pwm_servo_bank.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_servo_bank.sv
// rtl/pwm_servo_bank.sv - multi-channel frame-synchronous servo PWM bank (optional PWM_SLEW_EN duty slew limit)
module pwm_servo_bank #(
  parameter int NCH   = 4,
  parameter int CW    = 32,
  parameter int T_RST = 2000000,
  parameter int STEP  = 1000,
  localparam int WCH  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           res_n,
  input  logic           enable,
  input  logic [CW-1:0]  t,
  input  logic           wr,
  input  logic [WCH-1:0] wr_ch,
  input  logic [CW-1:0]  wr_d,
  output logic [NCH-1:0] pwm,
  output logic           frame
);

  // Reject unsupported channel counts and negative slew steps at elaboration.
  if (NCH < 1 || NCH > 16 || STEP < 0) begin : g_param_check
    $error("pwm_servo_bank: NCH must be 1..16 and STEP non-negative");
  end

`ifdef PWM_SLEW_EN
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  // Move act toward sh by at most STEP_C; differences are taken larger-minus-smaller.
  function automatic logic [CW-1:0] slew_toward(input logic [CW-1:0] act,
                                                input logic [CW-1:0] sh);
    logic [CW-1:0] res;
    if (sh > act) begin
      res = ((sh - act) > STEP_C) ? (act + STEP_C) : sh;
    end else begin
      res = ((act - sh) > STEP_C) ? (act - STEP_C) : sh;
    end
    return res;
  endfunction
`endif

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  t_act_q, t_act_d;
  logic [CW-1:0]  d_sh_q  [NCH];
  logic [CW-1:0]  d_sh_d  [NCH];
  logic [CW-1:0]  d_act_q [NCH];
  logic [CW-1:0]  d_act_d [NCH];
  logic [NCH-1:0] pwm_q, pwm_d;
  logic           frame_q, frame_d;

  logic [CW-1:0]  t_req;
  logic           wrap;
  logic           load;

  // Clamp the requested period to 2 and decide when shadow values are transferred.
  always_comb begin
    t_req = (t < CW'(2)) ? CW'(2) : t;
    wrap  = enable && (cnt_q == (t_act_q - CW'(1)));
    load  = !enable || wrap;
  end

  // Frame counter runs only while enabled and restarts at the wrap; period reloads on load.
  always_comb begin
    cnt_d   = '0;
    t_act_d = t_act_q;
    if (enable && !wrap) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (load) begin
      t_act_d = t_req;
    end
  end

  // Shadow duties take writes immediately; active duties follow the shadows only on load.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      d_sh_d[i]  = d_sh_q[i];
      d_act_d[i] = d_act_q[i];
      if (wr && (wr_ch == WCH'(i))) begin
        d_sh_d[i] = wr_d;
      end
      if (load) begin
`ifdef PWM_SLEW_EN
        d_act_d[i] = slew_toward(d_act_q[i], d_sh_q[i]);
`else
        d_act_d[i] = d_sh_q[i];
`endif
      end
    end
  end

  // Outputs compare the current count against each active duty; frame marks count zero.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = enable && (cnt_q < d_act_q[i]);
    end
    frame_d = enable && (cnt_q == '0);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_q   <= '0;
      t_act_q <= CW'(T_RST);
      pwm_q   <= '0;
      frame_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        d_sh_q[i]  <= '0;
        d_act_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      t_act_q <= t_act_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
      for (int i = 0; i < NCH; i++) begin
        d_sh_q[i]  <= d_sh_d[i];
        d_act_q[i] <= d_act_d[i];
      end
    end
  end

  assign pwm   = pwm_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_pwm_servo_bank.sv
// tb/tb_pwm_servo_bank.sv - self-checking bench for pwm_servo_bank
module tb_pwm_servo_bank;
  localparam int NCH   = 5;
  localparam int CW    = 32;
  localparam int T_RST = 64;
  localparam int STEP  = 100;
  localparam int WCH   = 3;
  localparam int HSZ   = 65536;

  logic           clk    = 1'b0;
  logic           res_n  = 1'b1;
  logic           enable = 1'b0;
  logic [CW-1:0]  t      = '0;
  logic           wr     = 1'b0;
  logic [WCH-1:0] wr_ch  = '0;
  logic [CW-1:0]  wr_d   = '0;
  logic [NCH-1:0] pwm;
  logic           frame;

  pwm_servo_bank #(.NCH(NCH), .CW(CW), .T_RST(T_RST), .STEP(STEP)) dut (
    .clk(clk), .res_n(res_n), .enable(enable), .t(t), .wr(wr),
    .wr_ch(wr_ch), .wr_d(wr_d), .pwm(pwm), .frame(frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // input history as seen by the DUT at each rising edge
  int             edge_n   = 0;
  int             rst_edge = 0;
  logic [CW-1:0]  t_hist [HSZ];
  logic           w_en   [HSZ];
  logic [WCH-1:0] w_ch_h [HSZ];
  logic [CW-1:0]  w_d_h  [HSZ];

  always @(posedge clk) begin
    if (edge_n < HSZ - 1) edge_n = edge_n + 1;
    t_hist[edge_n] = t;
    w_en[edge_n]   = wr && res_n;
    w_ch_h[edge_n] = wr_ch;
    w_d_h[edge_n]  = wr_d;
  end

  // frame monitor: one record per completed frame
  typedef struct packed {
    int                   f_edge;
    int                   len;
    logic [NCH-1:0][31:0] hi;
    logic                 shape_ok;
  } frec_t;

  frec_t frq[$];
  int    epoch = 0, epoch_seen = 0;
  bit    mon_active = 0;
  int    cur_f, cur_len;
  int    cur_hi [NCH];
  bit    cur_fell [NCH];
  bit    cur_ok;

  always @(negedge clk) begin
    frec_t rr;
    if (!res_n || epoch_seen != epoch) begin
      mon_active = 0;
      epoch_seen = epoch;
    end
    if (res_n && frame === 1'b1) begin
      if (mon_active) begin
        rr.f_edge = cur_f;
        rr.len = cur_len;
        rr.shape_ok = cur_ok;
        for (int c = 0; c < NCH; c++) rr.hi[c] = cur_hi[c];
        frq.push_back(rr);
      end
      mon_active = 1;
      cur_f = edge_n;
      cur_len = 0;
      cur_ok = 1;
      for (int c = 0; c < NCH; c++) begin
        cur_hi[c] = 0;
        cur_fell[c] = 0;
      end
    end
    if (mon_active) begin
      cur_len++;
      for (int c = 0; c < NCH; c++) begin
        if (pwm[c] === 1'b1) begin
          if (cur_fell[c]) cur_ok = 0;
          cur_hi[c]++;
        end else begin
          cur_fell[c] = 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int rd_idx = 0;
  int mdl_d [NCH];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic write(input int ch, input int d);
    wr = 1'b1;
    wr_ch = WCH'(ch);
    wr_d = CW'(d);
    step(1);
    wr = 1'b0;
  endtask

  task automatic mwrite(input int ch, input int d);
    write(ch, d);
    if (ch < NCH) mdl_d[ch] = d;
  endtask

  task automatic wait_frame(input string nm);
    int i;
    i = 0;
    while (frame !== 1'b1 && i < 5000) begin
      step(1);
      i++;
    end
    n_checks++;
    if (frame !== 1'b1) begin
      n_err++;
      $display("FAIL %s: got no frame pulse expected one within 5000 cycles", nm);
    end
  endtask

  task automatic get_frame(output frec_t r, output bit ok, input string nm, input int budget);
    int i;
    i = 0;
    while (rd_idx >= frq.size() && i < budget) begin
      step(1);
      i++;
    end
    ok = (rd_idx < frq.size());
    n_checks++;
    if (ok) begin
      r = frq[rd_idx];
      rd_idx++;
    end else begin
      r = '0;
      n_err++;
      $display("FAIL %s: got no completed frame expected one within %0d cycles", nm, budget);
    end
  endtask

  task automatic chk_rec(input string nm, input frec_t r, input int exp_len,
                         input logic [NCH-1:0][31:0] eh);
    chk({nm, ".len"}, r.len, exp_len);
    for (int c = 0; c < NCH; c++) chk($sformatf("%s.hi%0d", nm, c), r.hi[c], eh[c]);
    chk({nm, ".shape"}, r.shape_ok, 1);
  endtask

  function automatic logic [NCH-1:0][31:0] model_hi(input int len);
    logic [NCH-1:0][31:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (mdl_d[c] < len) ? mdl_d[c] : len;
    return v;
  endfunction

  function automatic int duty_at(input int e, input int ch);
    for (int k = e; k > rst_edge; k--) begin
      if (w_en[k] === 1'b1 && int'(w_ch_h[k]) == ch) return int'(w_d_h[k]);
    end
    return 0;
  endfunction

  typedef struct {
    int ch;
    int d;
    int t;
    int exp_len;
    int exp_hi;
  } row_t;

  row_t rows [11];

  initial begin
    frec_t r;
    bit ok;
    logic [NCH-1:0][31:0] eh;
    int slew_exp [5];
    int start_idx;

    rows[0]  = '{0, 250, 1000, 1000, 250};
    rows[1]  = '{1, 500, 1000, 1000, 500};
    rows[2]  = '{2, 0, 1000, 1000, 0};
    rows[3]  = '{3, 1000, 1000, 1000, 1000};
    rows[4]  = '{4, 5000, 1000, 1000, 1000};
    rows[5]  = '{7, 123, 1000, 1000, -1};
    rows[6]  = '{5, 77, 40, 40, -1};
    rows[7]  = '{0, 1, 0, 2, 1};
    rows[8]  = '{2, 1, 1, 2, 1};
    rows[9]  = '{3, 7, 7, 7, 7};
    rows[10] = '{1, 6, 7, 7, 6};
    for (int c = 0; c < NCH; c++) mdl_d[c] = 0;

    // reset state, then run straight out of reset: first frame uses the reset period
    enable = 1'b1;
    t = CW'(100);
    #1 res_n = 1'b0;
    #1;
    chk("reset.pwm", pwm, 0);
    chk("reset.frame", frame, 0);
    step(2);
    res_n = 1'b1;
    get_frame(r, ok, "rststart.f0", 400);
    if (ok) chk_rec("rststart.f0", r, T_RST, '0);
    get_frame(r, ok, "rststart.f1", 400);
    if (ok) chk_rec("rststart.f1", r, 100, '0);

    // table: write while idle, then measure the first frame after enable
    for (int k = 0; k < 11; k++) begin
      enable = 1'b0;
      epoch++;
      step(1);
      chk($sformatf("row%0d.fall.pwm", k), pwm, 0);
      chk($sformatf("row%0d.fall.frame", k), frame, 0);
      mwrite(rows[k].ch, rows[k].d);
      t = CW'(rows[k].t);
      step(60);
      rd_idx = frq.size();
      enable = 1'b1;
      step(1);
      chk($sformatf("row%0d.rise.frame", k), frame, 1);
      get_frame(r, ok, $sformatf("row%0d", k), 2 * rows[k].exp_len + 40);
      if (ok) begin
        chk($sformatf("row%0d.tlen", k), r.len, rows[k].exp_len);
        if (rows[k].ch < NCH)
          chk($sformatf("row%0d.thi", k), r.hi[rows[k].ch], rows[k].exp_hi);
        chk_rec($sformatf("row%0d", k), r, rows[k].exp_len, model_hi(rows[k].exp_len));
      end
    end

`ifndef PWM_SLEW_EN
    // mid-frame duty write and mid-frame period change
    enable = 1'b0;
    epoch++;
    step(1);
    mwrite(0, 250); mwrite(1, 500); mwrite(2, 0); mwrite(3, 0); mwrite(4, 0);
    t = CW'(1000);
    step(3);
    rd_idx = frq.size();
    enable = 1'b1;
    wait_frame("plan.start");
    step(99);
    write(0, 600);
    wait_frame("plan.second");
    step(200);
    t = CW'(2000);
    eh = '0; eh[0] = 250; eh[1] = 500;
    get_frame(r, ok, "plan.f0", 3000);
    if (ok) chk_rec("plan.f0", r, 1000, eh);
    eh[0] = 600;
    get_frame(r, ok, "plan.f1", 3000);
    if (ok) chk_rec("plan.f1", r, 1000, eh);
    get_frame(r, ok, "plan.f2", 5000);
    if (ok) chk_rec("plan.f2", r, 2000, eh);

    // writes one cycle before the wrap and on the wrap itself
    enable = 1'b0;
    epoch++;
    step(1);
    t = CW'(20);
    step(3);
    rd_idx = frq.size();
    enable = 1'b1;
    wait_frame("wrap.start");
    step(17);
    write(3, 5);
    write(2, 9);
    eh = '0; eh[0] = 20; eh[1] = 20;
    get_frame(r, ok, "wrap.f0", 100);
    if (ok) chk_rec("wrap.f0", r, 20, eh);
    eh[3] = 5;
    get_frame(r, ok, "wrap.f1", 100);
    if (ok) chk_rec("wrap.f1", r, 20, eh);
    eh[2] = 9;
    get_frame(r, ok, "wrap.f2", 100);
    if (ok) chk_rec("wrap.f2", r, 20, eh);

    // asynchronous reset in the middle of a frame
    enable = 1'b0;
    epoch++;
    step(1);
    t = CW'(1000);
    step(3);
    enable = 1'b1;
    wait_frame("arst.start");
    step(299);
    chk("arst.pre", pwm[1:0], 2'b11);
    #2;
    res_n = 1'b0;
    rst_edge = edge_n;
    enable = 1'b0;
    #1;
    chk("arst.pwm", pwm, 0);
    chk("arst.frame", frame, 0);
    for (int c = 0; c < NCH; c++) mdl_d[c] = 0;
    step(2);
    res_n = 1'b1;
    step(3);
    rd_idx = frq.size();
    enable = 1'b1;
    get_frame(r, ok, "arst.f0", 2100);
    if (ok) chk_rec("arst.f0", r, 1000, '0);
`endif

    // channel 0 step from 0 to 350
`ifdef PWM_SLEW_EN
    slew_exp = '{100, 200, 300, 350, 350};
`else
    slew_exp = '{350, 350, 350, 350, 350};
`endif
    enable = 1'b0;
    epoch++;
    step(1);
    write(0, 0);
    t = CW'(400);
    step(10);
    rd_idx = frq.size();
    enable = 1'b1;
    wait_frame("slew.start");
    step(10);
    write(0, 350);
    get_frame(r, ok, "slew.f0", 900);
    if (ok) chk("slew.f0.hi0", r.hi[0], 0);
    for (int j = 0; j < 5; j++) begin
      get_frame(r, ok, $sformatf("slew.f%0d", j + 1), 900);
      if (ok) chk($sformatf("slew.f%0d.hi0", j + 1), r.hi[0], slew_exp[j]);
    end

`ifndef PWM_SLEW_EN
    // random writes and period changes against the input-history model
    enable = 1'b0;
    epoch++;
    step(1);
    t = CW'(30);
    step(3);
    rd_idx = frq.size();
    start_idx = rd_idx;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        wr = 1'b1;
        wr_ch = WCH'($urandom_range(7));
        wr_d = CW'($urandom_range(60));
      end else begin
        wr = 1'b0;
      end
      if ($urandom_range(199) == 0) t = CW'($urandom_range(45));
      step(1);
    end
    wr = 1'b0;
    step(200);
    chk("rnd.enough_frames", (frq.size() - start_idx) > 20, 1);
    for (int k = start_idx; k < frq.size(); k++) begin
      int el, dv;
      r = frq[k];
      el = (t_hist[r.f_edge - 1] < 2) ? 2 : int'(t_hist[r.f_edge - 1]);
      eh = '0;
      for (int c = 0; c < NCH; c++) begin
        dv = duty_at(r.f_edge - 2, c);
        eh[c] = (dv < el) ? dv : el;
      end
      chk_rec($sformatf("rnd.f%0d", r.f_edge), r, el, eh);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
